ram8_arbiter: RTL and testbench

- Shares one RAM8 (8 x 16-bit register file) between two requester ports, A and B.
- Uses a round-robin arbiter and a three-state access sequencer.
- Latches the winning command, drives the RAM8 enable/rw/address/data pins for exactly one cycle, captures read data, and returns a one-cycle ack.
- Sits between two bus masters (e.g. CPU datapath and loader/DMA) and the RAM8 instance.

---
 rtl/ram8_arb_pkg.sv | 21 ++
 rtl/ram8_arbiter_rr_arb2.sv | 46 ++++
 rtl/ram8_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram8_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram8_arb_pkg.sv
// ram8_arb_pkg
//   Shared encodings for the RAM8 two-port arbiter.
//   - state_t : access sequencer states
//   - RW_*    : mem_rw / requester we encoding
//   - ID_*    : requester identifiers; also the bit index of each
//               requester inside the 2-bit req/grant vectors
package ram8_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage

// File: rtl/ram8_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter.
//   Ports:
//     clk      in   system clock, rising edge
//     reset    in   asynchronous active-high reset (pointer -> A)
//     req      in   [1:0] request vector, bit ID_A = A, bit ID_B = B
//     advance  in   the current grant has been taken; move the pointer
//     grant    out  [1:0] one-hot grant (all zero when nobody requests)
//     pointer  out  registered priority pointer (side that wins a tie)
//
//   The grant is combinational from req and the registered pointer; the
//   caller registers whatever it derives from it.
module rr_arb2
    import ram8_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       pointer
);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        grant = 2'b00;
        if (req == 2'b11) begin
            grant[pointer] = 1'b1;
        end else begin
            grant = req;
        end
    end

    // The side that just won loses the next tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pointer <= ID_A;
        end else if (advance) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of process order.
            pointer <= grant[ID_A] ? ID_B : ID_A;
        end
    end

endmodule

// File: rtl/ram8_arbiter.sv
// ram8_arbiter
//   Shares one RAM8 (8 x 16-bit register file) between requesters A and B.
//   A round-robin arbiter picks a winner in IDLE; its command is latched,
//   driven onto the RAM pins for exactly one ACCESS cycle, and the winner
//   gets a one-cycle ack in RESP. Every output is a flop.
//   Ports:
//     clk, reset                  clock / asynchronous active-high reset
//     a_req, a_we, a_addr, a_wdata  requester A command (held until a_ack)
//     a_ack                       one-cycle pulse: A's access completed
//     b_req, b_we, b_addr, b_wdata, b_ack   same for requester B
//     rdata                       read data, valid while a_ack/b_ack is high
//     mem_en, mem_rw, mem_addr, mem_wdata   to RAM8 en / rw / address / in
//     mem_rdata                   from RAM8 out (combinational read port)
//     busy                        high whenever the sequencer is not IDLE
module ram8_arbiter
    import ram8_arb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t state_q, state_d;

    logic [1:0]        req, grant;
    logic              pointer;
    logic              win, sel_id, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              cmd_we;

    logic cmd_load, rdata_load;
    logic mem_en_d, mem_rw_d, a_ack_d, b_ack_d, busy_d;

    // Bit position in req/grant equals the requester id.
    assign req = {b_req, a_req};

    // The pointer moves as soon as a grant is taken. It is only consulted in
    // IDLE, so this is indistinguishable from moving it at the end of RESP,
    // and during ACCESS/RESP it always names the side that is NOT being
    // served -- which is how the ack is steered below.
    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (cmd_load),
        .grant   (grant),
        .pointer (pointer)
    );

    // Winner's command mux.
    always_comb begin
        win       = |grant;
        sel_id    = grant[ID_B];
        sel_we    = (sel_id == ID_B) ? b_we    : a_we;
        sel_addr  = (sel_id == ID_B) ? b_addr  : a_addr;
        sel_wdata = (sel_id == ID_B) ? b_wdata : a_wdata;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (win) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, so each output
    // flop holds the value belonging to the state being entered.
    always_comb begin
        cmd_load   = (state_q == ST_IDLE) && win;
        mem_en_d   = cmd_load;
        mem_rw_d   = cmd_load && (sel_we == RW_WRITE);
        a_ack_d    = (state_q == ST_ACCESS) && (pointer == ID_B);
        b_ack_d    = (state_q == ST_ACCESS) && (pointer == ID_A);
        busy_d     = (state_d != ST_IDLE);
        rdata_load = (state_q == ST_ACCESS) && (cmd_we == RW_READ);
    end

    // Output and command registers. mem_addr/mem_wdata double as the latched
    // command, so later changes on the requester inputs cannot reach the RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_rw    <= RW_READ;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            busy      <= 1'b0;
            cmd_we    <= RW_READ;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            mem_en <= mem_en_d;
            mem_rw <= mem_rw_d;
            a_ack  <= a_ack_d;
            b_ack  <= b_ack_d;
            busy   <= busy_d;
            if (cmd_load) begin
                cmd_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            // RAM read data is valid during ACCESS; capture at its closing edge.
            if (rdata_load) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram8_arbiter.sv
// tb_ram8_arbiter
//   Self-checking bench for ram8_arbiter. A behavioural RAM8 sits on the
//   memory pins. Each burst hands a list of commands to each requester;
//   a reference model predicts grant order, ack cycle and read data and
//   queues the expectations; a monitor on the falling edge compares every
//   RAM access and every ack against the head of that queue.
module tb_ram8_arbiter;
    import ram8_arb_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_ack, b_ack;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;

    ram8_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural RAM8: combinational read, write on the rising edge.
    logic [DATA_W-1:0] ram [8] = '{default: '0};
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_en && mem_rw) ram[mem_addr] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic              side;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int                ack_cyc;
    } exp_t;

    cmd_t cmd_a[$];
    cmd_t cmd_b[$];
    exp_t exp_q[$];

    // Reference model state: memory contents, last read value, tie priority.
    logic [DATA_W-1:0] ref_mem [8] = '{default: '0};
    logic [DATA_W-1:0] last_rdata = '0;
    logic              prefer_b   = 1'b0;

    function automatic cmd_t mk(input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] d);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = d;
        return c;
    endfunction

    function automatic cmd_t rand_cmd(input bit avoid3);
        cmd_t c;
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = 3'($urandom_range(0, 7));
        c.wdata = 16'($urandom);
        if (avoid3 && c.addr == 3'd3) c.addr = 3'd4;
        return c;
    endfunction

    // Walk the two command lists: the first grant is sampled at edge s0,
    // each access occupies three cycles, a tie goes to the side that did
    // not win last, and the ack appears the cycle after the RAM access.
    task automatic predict(input int s0);
        int   ia = 0, ib = 0, s = s0;
        logic w;
        cmd_t c;
        exp_t e;
        while (ia < cmd_a.size() || ib < cmd_b.size()) begin
            if (ia < cmd_a.size() && ib < cmd_b.size()) w = prefer_b;
            else w = (ib < cmd_b.size());
            if (w) begin c = cmd_b[ib]; ib++; end
            else   begin c = cmd_a[ia]; ia++; end
            e.side = w; e.we = c.we; e.addr = c.addr; e.wdata = c.wdata;
            if (c.we) begin
                ref_mem[c.addr] = c.wdata;
            end else begin
                last_rdata = ref_mem[c.addr];
            end
            e.rdata   = last_rdata;
            e.ack_cyc = s + 1;
            exp_q.push_back(e);
            prefer_b = ~w;
            s += 3;
        end
    endtask

    // Issue the queued commands. With corrupt set, A's command inputs are
    // scrambled during the ACCESS cycle of its first access.
    task automatic run_burst(input bit corrupt);
        int  ia = 0, ib = 0;
        int  na, nb;
        @(posedge clk); #1;
        na = cmd_a.size();
        nb = cmd_b.size();
        predict(cyc + 1);
        if (na > 0) begin
            a_req = 1'b1; a_we = cmd_a[0].we; a_addr = cmd_a[0].addr; a_wdata = cmd_a[0].wdata;
        end
        if (nb > 0) begin
            b_req = 1'b1; b_we = cmd_b[0].we; b_addr = cmd_b[0].addr; b_wdata = cmd_b[0].wdata;
        end
        for (int t = 0; t < 200 && (ia < na || ib < nb); t++) begin
            @(posedge clk); #1;
            if (corrupt && t == 0) begin
                a_addr  = ~a_addr;
                a_wdata = ~a_wdata;
            end
            if (a_ack) begin
                ia++;
                if (ia < na) begin
                    a_we = cmd_a[ia].we; a_addr = cmd_a[ia].addr; a_wdata = cmd_a[ia].wdata;
                end else begin
                    a_req = 1'b0;
                end
            end
            if (b_ack) begin
                ib++;
                if (ib < nb) begin
                    b_we = cmd_b[ib].we; b_addr = cmd_b[ib].addr; b_wdata = cmd_b[ib].wdata;
                end else begin
                    b_req = 1'b0;
                end
            end
        end
        check("burst_completed", 32'(ia == na && ib == nb), 32'd1);
        a_req = 1'b0;
        b_req = 1'b0;
        cmd_a.delete();
        cmd_b.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        prefer_b   = 1'b0;
        last_rdata = '0;
    endtask

    // Monitor: compares RAM pin activity and acks against the expectation queue.
    bit   mon_en  = 1'b0;
    logic prev_en = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (mem_en) begin
                check("mem_en_back_to_back", 32'(prev_en), 32'd0);
                check("mem_en_has_expectation", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    check("mem_rw", 32'(mem_rw), 32'(e.we));
                    check("mem_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                    check("mem_en_cycle", cyc, e.ack_cyc - 1);
                    check("busy_in_access", 32'(busy), 32'd1);
                end
            end
            if (a_ack || b_ack) begin
                check("acks_exclusive", 32'(a_ack && b_ack), 32'd0);
                check("ack_has_expectation", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("ack_side", 32'(b_ack), 32'(e.side));
                    check("ack_cycle", cyc, e.ack_cyc);
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    check("busy_in_resp", 32'(busy), 32'd1);
                end
            end
        end
        prev_en = mem_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_rw", 32'(mem_rw), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_a_ack", 32'(a_ack), 32'd0);
        check("rst_b_ack", 32'(b_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // A writes BEEF to 5, then B reads it back.
        cmd_a.push_back(mk(1'b1, 3'd5, 16'hBEEF));
        run_burst(1'b0);
        cmd_b.push_back(mk(1'b0, 3'd5, 16'h0000));
        run_burst(1'b0);
        check("rdata_held_after_read", 32'(rdata), 32'hBEEF);

        // Simultaneous requests straight out of reset: A first; edge addresses.
        do_reset();
        cmd_a.push_back(mk(1'b1, 3'd0, 16'd1));
        cmd_b.push_back(mk(1'b1, 3'd7, 16'd2));
        run_burst(1'b0);
        cmd_a.push_back(mk(1'b0, 3'd0, 16'd0));
        cmd_b.push_back(mk(1'b0, 3'd7, 16'd0));
        run_burst(1'b0);

        // Continuous contention: six accesses alternating A, B.
        for (int i = 0; i < 3; i++) begin
            cmd_a.push_back(rand_cmd(1'b1));
            cmd_b.push_back(rand_cmd(1'b1));
        end
        run_burst(1'b0);

        // Command inputs changing during ACCESS must not reach the RAM.
        cmd_a.push_back(mk(1'b1, 3'd6, 16'h5A5A));
        run_burst(1'b1);
        cmd_b.push_back(mk(1'b0, 3'd6, 16'h0000));
        run_burst(1'b0);

        // Reset in the middle of A's write to address 3.
        @(posedge clk); #1;
        mon_en = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd3; a_wdata = 16'h1234;
        @(posedge clk); #1;
        check("abort_in_access", 32'(mem_en), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_mem_rw", 32'(mem_rw), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        check("abort_rdata", 32'(rdata), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("abort_no_a_ack", 32'(a_ack), 32'd0);
        check("abort_no_b_ack", 32'(b_ack), 32'd0);
        check("abort_no_write", 32'(ram[3]), 32'd0);
        a_req = 1'b0;
        @(posedge clk); #1;
        reset      = 1'b0;
        prefer_b   = 1'b0;
        last_rdata = '0;
        mon_en     = 1'b1;
        cmd_a.push_back(mk(1'b0, 3'd3, 16'h0000));
        run_burst(1'b0);

        // Randomised bursts.
        for (int r = 0; r < 40; r++) begin
            int na = $urandom_range(0, 2);
            int nb = $urandom_range(0, 2);
            if (na == 0 && nb == 0) na = 1;
            for (int i = 0; i < na; i++) cmd_a.push_back(rand_cmd(1'b0));
            for (int i = 0; i < nb; i++) cmd_b.push_back(rand_cmd(1'b0));
            run_burst(1'b0);
        end

        repeat (3) @(posedge clk);
        check("expectations_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
